// File: rtl/pc_unit.sv
// Program-counter unit: selects the next fetch address from redirect, stall, RAS pop,
// jump/call target or sequential increment, and keeps a circular return-address stack.
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               INC          = 4,
    parameter int               RAS_DEPTH    = 4,
    parameter int               RAS_PTR_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [WIDTH-1:0]     redirect_addr,
    input  logic                 jump,
    input  logic [WIDTH-1:0]     jump_target,
    input  logic                 call,
    input  logic                 ret,
    output logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     pc_plus,
    output logic [RAS_PTR_W:0]   ras_count,
    output logic                 ras_overflow,
    output logic                 ras_underflow
);

    localparam logic [WIDTH-1:0]   INC_W   = WIDTH'(INC);
    localparam logic [RAS_PTR_W:0] CNT_MAX = (RAS_PTR_W + 1)'(RAS_DEPTH);

    logic [WIDTH-1:0]     r_pc;
    logic [RAS_PTR_W-1:0] r_top;
    logic [RAS_PTR_W:0]   r_count;
    logic                 r_overflow;
    logic                 r_underflow;
    logic [WIDTH-1:0]     r_ras [RAS_DEPTH];

    logic [WIDTH-1:0]     w_pc_plus;
    logic [WIDTH-1:0]     w_pc_next;
    logic [RAS_PTR_W-1:0] w_top_inc;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_underflow_set;
    logic                 w_full;

    assign w_pc_plus = r_pc + INC_W;
    assign w_top_inc = r_top + RAS_PTR_W'(1);
    assign w_full    = (r_count == CNT_MAX);

    // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_pc_next       = w_pc_plus;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        w_underflow_set = 1'b0;
        if (redirect) begin
            w_pc_next = redirect_addr;
        end else if (stall) begin
            w_pc_next = r_pc;
        end else if (ret) begin
            if (r_count != '0) begin
                w_pc_next = r_ras[r_top];
                w_pop     = 1'b1;
            end else begin
                w_underflow_set = 1'b1;
            end
        end else if (jump) begin
            w_pc_next = jump_target;
            w_push    = call;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_VECTOR;
            r_top       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (w_push) begin
                r_top <= w_top_inc;
                // A full stack keeps its count; the oldest entry is silently overwritten.
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
            if (w_pop) begin
                r_top   <= r_top - RAS_PTR_W'(1);
                r_count <= r_count - 1'b1;
            end
            if (w_underflow_set) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // NOTE: stack storage is deliberately not reset; ras_count marks which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[w_top_inc] <= w_pc_plus;
        end
    end

    assign pc            = r_pc;
    assign pc_plus       = w_pc_plus;
    assign ras_count     = r_count;
    assign ras_overflow  = r_overflow;
    assign ras_underflow = r_underflow;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus pushes model predictions into a queue,
// an independent monitor pops and compares them after every rising edge.
module tb_pc_unit;

    localparam int WIDTH     = 32;
    localparam int RAS_DEPTH = 4;
    localparam int RAS_PTR_W = 2;
    localparam logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             stall = 1'b0;
    logic             redirect = 1'b0;
    logic [WIDTH-1:0] redirect_addr = '0;
    logic             jump = 1'b0;
    logic [WIDTH-1:0] jump_target = '0;
    logic             call = 1'b0;
    logic             ret = 1'b0;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic [RAS_PTR_W:0] ras_count;
    logic             ras_overflow;
    logic             ras_underflow;

    pc_unit #(
        .WIDTH(WIDTH), .RESET_VECTOR(RESET_VECTOR), .INC(4),
        .RAS_DEPTH(RAS_DEPTH), .RAS_PTR_W(RAS_PTR_W)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_addr(redirect_addr), .jump(jump), .jump_target(jump_target),
        .call(call), .ret(ret), .pc(pc), .pc_plus(pc_plus),
        .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [2:0]       cnt;
        logic             ovf;
        logic             unf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: the stack is a plain queue, newest at the back.
    logic [WIDTH-1:0] m_pc;
    logic [WIDTH-1:0] m_ras[$];
    logic             m_ovf;
    logic             m_unf;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    endtask

    function automatic void model_reset();
        m_pc  = RESET_VECTOR;
        m_ras.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    task automatic step(input logic i_redir, input logic [WIDTH-1:0] i_raddr, input logic i_stall,
                        input logic i_ret, input logic i_jump, input logic [WIDTH-1:0] i_tgt,
                        input logic i_call);
        logic [WIDTH-1:0] dropped;
        redirect = i_redir; redirect_addr = i_raddr; stall = i_stall;
        ret = i_ret; jump = i_jump; jump_target = i_tgt; call = i_call;
        if (i_redir) begin
            m_pc = i_raddr;
        end else if (i_stall) begin
            m_pc = m_pc;
        end else if (i_ret) begin
            if (m_ras.size() > 0) begin
                m_pc = m_ras.pop_back();
            end else begin
                m_pc  = m_pc + 32'd4;
                m_unf = 1'b1;
            end
        end else if (i_jump) begin
            if (i_call) begin
                if (m_ras.size() == RAS_DEPTH) begin
                    dropped = m_ras.pop_front();
                    m_ovf   = 1'b1;
                end
                m_ras.push_back(m_pc + 32'd4);
            end
            m_pc = i_tgt;
        end else begin
            m_pc = m_pc + 32'd4;
        end
        exp_q.push_back(exp_t'{pc: m_pc, cnt: 3'(m_ras.size()), ovf: m_ovf, unf: m_unf});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, '0, 0, 0, 0, '0, 0);
    endtask

    task automatic redir(input logic [WIDTH-1:0] a);
        step(1, a, 0, 0, 0, '0, 0);
    endtask

    task automatic jcall(input logic [WIDTH-1:0] t);
        step(0, '0, 0, 0, 1, t, 1);
    endtask

    task automatic do_ret();
        step(0, '0, 0, 1, 0, '0, 0);
    endtask

    // Assert reset between edges and confirm the asynchronous effect before any clock.
    task automatic do_reset();
        @(negedge clk);
        #1;
        redirect = 0; stall = 0; ret = 0; jump = 0; call = 0;
        rst = 1'b1;
        #1;
        check("async_rst_pc", pc, RESET_VECTOR);
        check("async_rst_cnt", WIDTH'(ras_count), '0);
        check("async_rst_flags", WIDTH'({ras_overflow, ras_underflow}), '0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: the PC is presented every cycle, so one prediction is consumed per edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("pc", pc, mon_e.pc);
                check("pc_plus", pc_plus, mon_e.pc + 32'd4);
                check("ras_count", WIDTH'(ras_count), WIDTH'(mon_e.cnt));
                check("ras_overflow", WIDTH'(ras_overflow), WIDTH'(mon_e.ovf));
                check("ras_underflow", WIDTH'(ras_underflow), WIDTH'(mon_e.unf));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t required < 500000", $time);
        $fatal(1);
    end

    initial begin
        model_reset();
        #3;
        check("init_rst_pc", pc, RESET_VECTOR);
        check("init_rst_cnt", WIDTH'(ras_count), '0);
        @(negedge clk);
        rst = 1'b0;

        // Reach 0x40, reset mid-cycle, then three sequential edges.
        idle(16);
        do_reset();
        idle(3);

        // Call and return.
        redir(32'h10);
        jcall(32'h100);
        idle(1);
        do_ret();

        // Five nested calls overflow a four-entry stack, then unwind past empty.
        redir(32'h0);
        for (int i = 1; i <= 5; i++) jcall(WIDTH'(i) << 8);
        for (int i = 0; i < 5; i++) do_ret();

        // Stall swallows ret/jump; redirect overrides stall.
        do_reset();
        jcall(32'h1000);
        redir(32'h20);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 1, 1, 32'h500, 1);
        step(1, 32'h80, 1, 0, 0, '0, 0);

        // Redirect beats everything else in the same cycle.
        step(1, 32'h200, 0, 1, 1, 32'h900, 1);
        idle(1);

        // Address wrap, then pop beats jump.
        do_reset();
        redir(32'hFFFF_FFFC);
        idle(1);
        jcall(32'h300);
        step(0, '0, 0, 1, 1, 32'h700, 0);
        idle(1);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 50) do_reset();
            step($urandom_range(11) == 0, $urandom, $urandom_range(5) == 0,
                 $urandom_range(3) == 0, $urandom_range(2) == 0, $urandom,
                 $urandom_range(1) == 0);
        end

        repeat (3) @(negedge clk);
        #1;
        check("queue_drain", WIDTH'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
